// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Write-side front end of the register file. Core writeback has absolute
// priority; stream register-injection beats are buffered in a small FIFO and
// drained on cycles where the core does not write. All outputs are registered.
// Optional build macro: REGFILE_ARB_PROTECT_EN (drop stream writes to reg 0 and
// pulse protect_err for one cycle).
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          core_we,
    input  logic [ADDR_WIDTH-1:0]         core_addr,
    input  logic [DATA_WIDTH-1:0]         core_data,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic [ADDR_WIDTH-1:0]         s_tdest,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_addr,
    output logic [DATA_WIDTH-1:0]         rf_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          protect_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    // Entry layout: {tdest, tdata}
    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    head;

    // Ready only looks at registered occupancy, so a pop at full frees the
    // slot for the following cycle, never combinationally.
    assign s_tready = (count_q != LVL_W'(FIFO_DEPTH)) && reset;
    assign accept   = s_tvalid && s_tready;

`ifdef REGFILE_ARB_PROTECT_EN
    // Beats aimed at register 0 complete the handshake but are discarded.
    assign push = accept && (s_tdest != '0);
`else
    assign push = accept;
`endif

    assign pop  = !core_we && (count_q != '0);
    assign head = fifo_mem[rd_ptr_q];

    // Next-state: pointer/count bookkeeping and the core-first output mux.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (!reset) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            rf_addr_d = '0;
            rf_data_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + LVL_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - LVL_W'(1);
            end
            if (core_we) begin
                rf_we_d   = 1'b1;
                rf_addr_d = core_addr;
                rf_data_d = core_data;
            end else if (pop) begin
                rf_we_d   = 1'b1;
                rf_addr_d = head[ENTRY_W-1:DATA_WIDTH];
                rf_data_d = head[DATA_WIDTH-1:0];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        count_q   <= count_d;
        rf_we_q   <= rf_we_d;
        rf_addr_q <= rf_addr_d;
        rf_data_q <= rf_data_d;
    end

    // FIFO storage: no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {s_tdest, s_tdata};
        end
    end

`ifdef REGFILE_ARB_PROTECT_EN
    logic protect_err_q, protect_err_d;

    // Flag a dropped protected beat in the cycle after its acceptance.
    always_comb begin
        protect_err_d = reset && accept && (s_tdest == '0);
    end

    // Register the protection pulse.
    always_ff @(posedge clk) begin
        protect_err_q <= protect_err_d;
    end

    assign protect_err = protect_err_q;
`else
    assign protect_err = 1'b0;
`endif

    assign rf_we      = rf_we_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data    = rf_data_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed plan steps plus random traffic,
// checked against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_data;
    logic [DW-1:0] s_tdata;
    logic [AW-1:0] s_tdest;
    logic          s_tvalid;
    logic          s_tready;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [LW-1:0] fifo_level;
    logic          protect_err;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .core_we(core_we), .core_addr(core_addr), .core_data(core_data),
        .s_tdata(s_tdata), .s_tdest(s_tdest), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .fifo_level(fifo_level), .protect_err(protect_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending stream beats and the expected registered outputs.
    logic [AW+DW-1:0] q[$];
    logic             exp_we   = 1'b0;
    logic [AW-1:0]    exp_addr = '0;
    logic [DW-1:0]    exp_data = '0;
    logic             exp_err  = 1'b0;
    bit               accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance model at the edge,
    // then compare registered outputs.
    task automatic step(input bit rst_n, input bit cwe, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input bit tv,
                        input logic [AW-1:0] td, input logic [DW-1:0] tdat);
        logic [AW+DW-1:0] e;
        bit               rdy;
        reset = rst_n; core_we = cwe; core_addr = ca; core_data = cd;
        s_tvalid = tv; s_tdest = td; s_tdata = tdat;
        rdy = rst_n && (q.size() != DEPTH);
        #1;
        chk("s_tready", {63'd0, s_tready}, {63'd0, rdy});
        accepted = tv && rdy;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_err = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (cwe) begin
                exp_we = 1'b1; exp_addr = ca; exp_data = cd;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                exp_we = 1'b1; exp_addr = e[AW+DW-1:DW]; exp_data = e[DW-1:0];
            end else begin
                exp_we = 1'b0;
            end
            if (accepted) begin
`ifdef REGFILE_ARB_PROTECT_EN
                if (td == '0) exp_err = 1'b1;
                else q.push_back({td, tdat});
`else
                q.push_back({td, tdat});
`endif
            end
        end
        #1;
        chk("rf_we", {63'd0, rf_we}, {63'd0, exp_we});
        chk("rf_addr", {{(64-AW){1'b0}}, rf_addr}, {{(64-AW){1'b0}}, exp_addr});
        chk("rf_data", {{(64-DW){1'b0}}, rf_data}, {{(64-DW){1'b0}}, exp_data});
        chk("fifo_level", {{(64-LW){1'b0}}, fifo_level}, 64'(q.size()));
        chk("protect_err", {63'd0, protect_err}, {63'd0, exp_err});
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [AW-1:0] bd[6];
        logic [DW-1:0] bv[6];

        reset = 1'b0; core_we = 1'b0; core_addr = '0; core_data = '0;
        s_tvalid = 1'b0; s_tdest = '0; s_tdata = '0;

        // Reset: outputs zero, ready low even with a core write and a beat offered.
        step(1'b0, 1'b1, 8'd9, 32'h1, 1'b1, 8'd9, 32'h2);
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_level", {{(64-LW){1'b0}}, fifo_level}, 64'd0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

        // Plan 1: core write, one-cycle latency, then strobe drops.
        step(1'b1, 1'b1, 8'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        chk("tp1_we", {63'd0, rf_we}, 64'd1);
        chk("tp1_addr", {56'd0, rf_addr}, 64'd5);
        chk("tp1_data", {32'd0, rf_data}, 64'hDEADBEEF);
        idle();
        chk("tp1_we_low", {63'd0, rf_we}, 64'd0);

        // Plan 2: stream beat with idle core, two-cycle latency.
        step(1'b1, 1'b0, '0, '0, 1'b1, 8'd3, 32'h12);
        chk("tp2_level1", {{(64-LW){1'b0}}, fifo_level}, 64'd1);
        chk("tp2_we0", {63'd0, rf_we}, 64'd0);
        idle();
        chk("tp2_we", {63'd0, rf_we}, 64'd1);
        chk("tp2_addr", {56'd0, rf_addr}, 64'd3);
        chk("tp2_data", {32'd0, rf_data}, 64'h12);
        chk("tp2_level0", {{(64-LW){1'b0}}, fifo_level}, 64'd0);

        // Plan 3: core holds the port for 10 cycles while 6 beats are offered.
        for (int i = 0; i < 6; i++) begin
            bd[i] = AW'(8'd20 + 8'(i));
            bv[i] = 32'hC000_0000 + DW'(i);
        end
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 8'd1, DW'(c), idx < 6, bd[idx % 6], bv[idx % 6]);
            if (accepted) idx++;
        end
        chk("tp3_accepted", 64'(idx), 64'd4);
        #1;
        chk("tp3_tready_low", {63'd0, s_tready}, 64'd0);
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, '0, '0, idx < 6, bd[idx % 6], bv[idx % 6]);
            if (accepted) idx++;
        end
        chk("tp3_all_accepted", 64'(idx), 64'd6);

        // Plan 4: same-address core and stream writes commit core first.
        step(1'b1, 1'b1, 8'd7, 32'hA, 1'b1, 8'd7, 32'hB);
        chk("tp4_first", {32'd0, rf_data}, 64'hA);
        idle();
        chk("tp4_second", {32'd0, rf_data}, 64'hB);
        chk("tp4_addr", {56'd0, rf_addr}, 64'd7);
        idle();

        // Plan 5: fill three entries behind a busy core, then reset for a cycle.
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 8'd2, 32'h0, 1'b1, AW'(8'd40 + 8'(c)), 32'hF0 + DW'(c));
        end
        chk("tp5_level3", {{(64-LW){1'b0}}, fifo_level}, 64'd3);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("tp5_level0", {{(64-LW){1'b0}}, fifo_level}, 64'd0);
        for (int c = 0; c < 4; c++) begin
            idle();
            chk("tp5_no_stale", {63'd0, rf_we}, 64'd0);
        end

        // Plan 6: stream beat to register 0.
        step(1'b1, 1'b0, '0, '0, 1'b1, 8'd0, 32'h55);
        chk("tp6_accepted", {63'd0, accepted}, 64'd1);
        idle();
`ifdef REGFILE_ARB_PROTECT_EN
        chk("tp6_no_we", {63'd0, rf_we}, 64'd0);
        chk("tp6_err", {63'd0, protect_err}, 64'd0);
`else
        chk("tp6_we", {63'd0, rf_we}, 64'd1);
        chk("tp6_data", {32'd0, rf_data}, 64'h55);
        chk("tp6_err", {63'd0, protect_err}, 64'd0);
`endif
        idle();

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(99) >= 2,
                 $urandom_range(99) < 45, AW'($urandom), DW'($urandom),
                 $urandom_range(99) < 60, AW'($urandom_range(7)), DW'($urandom));
        end
        for (int c = 0; c < DEPTH + 2; c++) idle();
        chk("final_level", {{(64-LW){1'b0}}, fifo_level}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Write-side front end of the dual-read register file; drives its single write port (we/addr/data).
- Merges two write sources:
  - core pipeline writeback: priority, never stalled.
  - external AXI-stream register-injection channel: buffered in a small FIFO, drained on cycles where the core does not write.
- All outputs registered, so the register file sees clean, glitch-free write strobes.

Parameters:
- DATA_WIDTH, 32, width of register data.
- ADDR_WIDTH, 8, register address width (2**ADDR_WIDTH registers).
- FIFO_DEPTH, 4, stream FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- core_we  in  1  core writeback strobe.
- core_addr  in  ADDR_WIDTH  core writeback register address.
- core_data  in  DATA_WIDTH  core writeback data.
- s_tdata  in  DATA_WIDTH  stream write data.
- s_tdest  in  ADDR_WIDTH  stream target register address.
- s_tvalid  in  1  stream beat valid.
- s_tready  out  1  stream beat accepted when high with s_tvalid.
- rf_we  out  1  register file write enable.
- rf_addr  out  ADDR_WIDTH  register file write address.
- rf_data  out  DATA_WIDTH  register file write data.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- protect_err  out  1  one-cycle pulse on a dropped protected write; tied 0 when the Optional Feature is compiled out.

Behaviour:
- Reset (reset==0 at posedge clk):
  - rf_we=0, rf_addr=0, rf_data=0.
  - FIFO read/write pointers and count=0; fifo_level=0; protect_err=0.
  - s_tready=0 during the reset cycle.
  - In-flight FIFO contents are discarded. A core write presented during a reset cycle is lost.
- s_tready: combinational, equals (count != FIFO_DEPTH) && reset.
- Stream accept:
  - On s_tvalid && s_tready at posedge, {s_tdest, s_tdata} is pushed at tail; count increments.
  - Beats are never reordered.
- Output mux, evaluated each cycle, registered at posedge:
  - core_we=1: rf_we<=1, rf_addr<=core_addr, rf_data<=core_data; FIFO not popped.
  - else if count>0: head entry popped to rf_*, rf_we<=1.
  - else: rf_we<=0; rf_addr and rf_data hold their last values.
- Latency:
  - core write: 1 cycle (driven in cycle N, rf_we high in cycle N+1).
  - stream write, idle core: 2 cycles (accepted in cycle N, pushed at edge N; popped and rf_we high in cycle N+2).
- Simultaneous push and pop:
  - Count is unchanged.
  - A push while full is impossible, because s_tready is low when full.
  - A pop at count==FIFO_DEPTH frees a slot that is visible in the next cycle only; s_tready does not combinationally depend on the pop.
- Same-address conflict: a core write and a pending stream write to the same register are resolved by commit order. The core write commits first; the stream value commits later and overwrites it. This is intended; software must not inject into registers the running program writes.
- Starvation: continuous core_we stalls the FIFO indefinitely. The FIFO fills, s_tready drops, and the stream backpressures. No data loss.
- Pointer wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty are derived from count.
- fifo_level: registered count, updated at the same edge as the pointers.

Optional Feature:
- Macro: REGFILE_ARB_PROTECT_EN.
- Compiled in:
  - Stream beats with s_tdest==0 are accepted (handshake completes normally) but not pushed.
  - protect_err pulses high for exactly one cycle, the cycle after acceptance.
  - Core writes to address 0 are unaffected.
- Compiled out:
  - All stream addresses are pushed.
  - protect_err is constant 0.

Test Plan:
1. Reset, then core_we=1, addr=5, data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; following cycle rf_we=0.
2. Core idle; stream beat tdest=3, tdata=0x12 accepted in cycle N -> rf_we=1, addr 3, data 0x12 in cycle N+2; fifo_level 1 then 0.
3. core_we held high 10 cycles while the stream offers 6 beats (FIFO_DEPTH=4) -> 4 accepted, s_tready low after the 4th. On core release, 4 rf writes occur in order on consecutive cycles, then the remaining 2 beats follow.
4. Same cycle: core write addr 7 data 0xA plus stream beat addr 7 data 0xB -> rf write 7/0xA first, then 7/0xB one cycle later.
5. FIFO holding 3 entries, reset asserted low for 1 cycle -> fifo_level=0, rf_we=0, no stale entries emitted afterwards.
6. REGFILE_ARB_PROTECT_EN defined, stream beat tdest=0 data 0x55 -> handshake completes, no rf_we, protect_err=1 for one cycle. Macro undefined -> rf write 0/0x55, protect_err stays 0.
